button_event_ctrl: RTL

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

---
 rtl/button_event_ctrl_pkg.sv | 28 ++
 rtl/button_event_ctrl_sync_2ff.sv | 25 ++
 rtl/button_event_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared defaults, derived widths and arbiter state encoding for the
// button event controller.
package button_pkg;

  // Default channel count and debounce length.
  localparam int N_BTN_DEF     = 4;
  localparam int DB_CYCLES_DEF = 16;

  // Debounce counter width: counts 0..db-1, never narrower than one bit.
  function automatic int cnt_width(input int db);
    return (db <= 2) ? 1 : $clog2(db);
  endfunction

  // Event id width: indexes 0..n-1, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DB_CYCLES_DEF);
  localparam int ID_W_DEF  = id_width(N_BTN_DEF);

  // Arbiter FSM: either nothing offered, or one event held on evt_id.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/button_event_ctrl_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw bit through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Debounces N_BTN raw buttons and offers each press as a single event
// through a valid/ready port, arbitrating round-robin between channels.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic [N_BTN-1:0]         overflow
);

  localparam int ID_W  = $clog2(N_BTN);
  localparam int CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N_BTN - 1);

  logic [N_BTN-1:0] sync_s;
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] overflow_q, overflow_d;
  logic [N_BTN-1:0] clr_s;

  arb_state_e       state_q;
  logic             evt_valid_q;
  logic [ID_W-1:0]  evt_id_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_inc_s;
  logic [ID_W-1:0]  start_s;
  logic [ID_W-1:0]  pick_s;
  logic             hs_s;
  logic             take_s;

  // First set bit of pend at or above start, wrapping at N_BTN.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_BTN-1:0] pend,
                                              input logic [ID_W-1:0]  start);
    logic found;
    int   idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(start) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && pend[idx]) begin
        found   = 1'b1;
        rr_pick = ID_W'(idx);
      end
    end
  endfunction

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    logic             lvl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_full;

    sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw[gi]),
      .q   (sync_s[gi])
    );

    assign cnt_full     = (cnt_q == CNT_MAX);
    // A rise is the edge on which a disagreeing high level is finally adopted.
    assign rise_s[gi]   = sync_s[gi] && !lvl_q && cnt_full;
    assign btn_level[gi] = lvl_q;

    // Count consecutive disagreeing samples; adopt the new level on the last one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else if (sync_s[gi] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_full) begin
        lvl_q <= sync_s[gi];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Grant selection and pending/overflow next state. After a handshake the
  // search restarts just past the channel that was served.
  always_comb begin
    ptr_inc_s  = (evt_id_q == ID_LAST) ? '0 : evt_id_q + 1'b1;
    start_s    = (state_q == ST_OFFER) ? ptr_inc_s : ptr_q;
    pick_s     = rr_pick(pending_q, start_s);
    hs_s       = evt_valid_q && evt_ready;
    take_s     = (|pending_q) && ((state_q == ST_IDLE) || hs_s);
    clr_s      = '0;
    if (take_s) clr_s[pick_s] = 1'b1;
    // A new rise beats a same-edge clear; a rise onto an uncleared pending bit is lost.
    pending_d  = (pending_q & ~clr_s) | rise_s;
    overflow_d = overflow_q | (rise_s & pending_q & ~clr_s);
  end

  // Pending presses and sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Arbiter FSM with registered evt_valid/evt_id and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            evt_id_q    <= pick_s;
            evt_valid_q <= 1'b1;
            state_q     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            ptr_q <= ptr_inc_s;
            if (|pending_q) begin
              evt_id_q <= pick_s;
            end else begin
              evt_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign overflow  = overflow_q;

endmodule
